// File: rtl/miscv_pkg.sv
// Shared constants and types for the register-file read stage.
package miscv_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int NREGS  = 8;
  localparam int NRD    = 2;  // decode-side read ports

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/regfile_read_stage_if.sv
// Write-back, decode-read and operand-latch signals of the read stage.
interface regfile_read_stage_if;
  import miscv_pkg::*;
  logic      wb_en;
  reg_addr_t wb_addr;
  word_t     wb_data;
  logic      in_valid;
  reg_addr_t rs1_addr;
  reg_addr_t rs2_addr;
  logic      stall;
  logic      flush;
  word_t     op1_q;
  word_t     op2_q;
  reg_addr_t rs1_q;
  reg_addr_t rs2_q;
  logic      out_valid;

  modport master (output wb_en, wb_addr, wb_data, in_valid, rs1_addr, rs2_addr,
                  stall, flush,
                  input  op1_q, op2_q, rs1_q, rs2_q, out_valid);
  modport slave  (input  wb_en, wb_addr, wb_data, in_valid, rs1_addr, rs2_addr,
                  stall, flush,
                  output op1_q, op2_q, rs1_q, rs2_q, out_valid);
endinterface

// File: rtl/regfile_8x16.sv
// 8x16 register array, one write port, NRD write-first bypassed read ports.
// MISCV_ZERO_REG_EN: register 0 is hardwired to zero and writes to it vanish.
module regfile_8x16
  import miscv_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wbEn,
  input  reg_addr_t                     wbAddr,
  input  word_t                         wbData,
  input  logic [NRD-1:0][ADDR_W-1:0]    rdAddr,
  output logic [NRD-1:0][DATA_W-1:0]    rdData,
  output logic                          wrEff   // write actually lands
);
  word_t regs [NREGS];

`ifdef MISCV_ZERO_REG_EN
  assign wrEff = wbEn && (wbAddr != '0);
`else
  assign wrEff = wbEn;
`endif

  // Array write; reset clears every entry
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wrEff) begin
      regs[wbAddr] <= wbData;
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : gRd
    word_t rd;
    // Read lookup with same-cycle write forwarded in
    always_comb begin
      rd = regs[rdAddr[g]];
      if (wrEff && (wbAddr == rdAddr[g])) rd = wbData;
`ifdef MISCV_ZERO_REG_EN
      if (rdAddr[g] == '0) rd = '0;
`endif
    end
    assign rdData[g] = rd;
  end
endmodule

// File: rtl/regfile_read_stage.sv
// Register-file read stage: regfile_8x16 plus the ID/EX operand latch with
// flush > stall > normal priority. A write during stall refreshes any held
// operand whose latched source matches, so execute never sees stale data.
// Optional: MISCV_ZERO_REG_EN (handled inside regfile_8x16).
module regfile_read_stage
  import miscv_pkg::*;
(
  input logic                  clk,
  input logic                  reset,
  regfile_read_stage_if.slave  bus
);
  logic [NRD-1:0][ADDR_W-1:0] rdAddr;
  logic [NRD-1:0][DATA_W-1:0] rdData;
  logic [NRD-1:0][DATA_W-1:0] opQ;
  logic [NRD-1:0][ADDR_W-1:0] rsQ;
  logic                       wrEff;
  logic                       vldQ;

  assign rdAddr = {bus.rs2_addr, bus.rs1_addr};

  regfile_8x16 uRf (
    .clk    (clk),
    .reset  (reset),
    .wbEn   (bus.wb_en),
    .wbAddr (bus.wb_addr),
    .wbData (bus.wb_data),
    .rdAddr (rdAddr),
    .rdData (rdData),
    .wrEff  (wrEff)
  );

  for (genvar g = 0; g < NRD; g++) begin : gLane
    word_t     op;
    reg_addr_t rs;
    // Operand/source latch for one read port
    always_ff @(posedge clk) begin
      if (reset || bus.flush) begin
        op <= '0;
        rs <= '0;
      end else if (bus.stall) begin
        if (wrEff && (bus.wb_addr == rs)) op <= bus.wb_data;
      end else begin
        op <= rdData[g];
        rs <= rdAddr[g];
      end
    end
    assign opQ[g] = op;
    assign rsQ[g] = rs;
  end

  // Valid bit follows in_valid unless held by stall or squashed
  always_ff @(posedge clk) begin
    if (reset || bus.flush) vldQ <= 1'b0;
    else if (!bus.stall)    vldQ <= bus.in_valid;
  end

  assign bus.op1_q     = opQ[0];
  assign bus.op2_q     = opQ[1];
  assign bus.rs1_q     = rsQ[0];
  assign bus.rs2_q     = rsQ[1];
  assign bus.out_valid = vldQ;
endmodule

// File: tb/tb_regfile_read_stage.sv
// Self-checking bench: directed plan cases plus random traffic against a
// behavioural model of the register file and operand latch.
module tb_regfile_read_stage;
  logic clk = 1'b0;
  logic reset;
  int   nCmp = 0;
  int   nErr = 0;

  regfile_read_stage_if rif ();

  regfile_read_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (rif.slave)
  );

  always #5 clk = ~clk;

`ifdef MISCV_ZERO_REG_EN
  localparam bit ZERO = 1'b1;
`else
  localparam bit ZERO = 1'b0;
`endif

  // Model state
  logic [15:0] mRegs [8];
  logic [15:0] mOp1, mOp2;
  logic [2:0]  mRs1, mRs2;
  logic        mVld;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nCmp++;
    if (obs !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mRead(input logic [2:0] a, input logic we,
                                        input logic [2:0] wa, input logic [15:0] wd);
    if (ZERO && a == 3'd0) return 16'h0;
    if (we && wa == a && !(ZERO && wa == 3'd0)) return wd;
    return mRegs[a];
  endfunction

  // One clock: drive inputs, advance model, check all outputs after the edge
  task automatic step(input logic r, input logic we, input logic [2:0] wa,
                      input logic [15:0] wd, input logic iv, input logic [2:0] a1,
                      input logic [2:0] a2, input logic st, input logic fl);
    logic [15:0] nOp1, nOp2;
    logic [2:0]  nRs1, nRs2;
    logic        nVld;
    logic        wrOk;
    reset = r; rif.wb_en = we; rif.wb_addr = wa; rif.wb_data = wd;
    rif.in_valid = iv; rif.rs1_addr = a1; rif.rs2_addr = a2;
    rif.stall = st; rif.flush = fl;
    wrOk = we && !(ZERO && wa == 3'd0);
    nOp1 = mOp1; nOp2 = mOp2; nRs1 = mRs1; nRs2 = mRs2; nVld = mVld;
    if (r || fl) begin
      nOp1 = 0; nOp2 = 0; nRs1 = 0; nRs2 = 0; nVld = 0;
    end else if (st) begin
      if (wrOk && wa == mRs1) nOp1 = wd;
      if (wrOk && wa == mRs2) nOp2 = wd;
    end else begin
      nOp1 = mRead(a1, we, wa, wd);
      nOp2 = mRead(a2, we, wa, wd);
      nRs1 = a1; nRs2 = a2; nVld = iv;
    end
    @(posedge clk);
    if (r) for (int i = 0; i < 8; i++) mRegs[i] = 16'h0;
    else if (wrOk) mRegs[wa] = wd;
    mOp1 = nOp1; mOp2 = nOp2; mRs1 = nRs1; mRs2 = nRs2; mVld = nVld;
    #1;
    chk("op1_q", rif.op1_q, mOp1);
    chk("op2_q", rif.op2_q, mOp2);
    chk("rs1_q", 16'(rif.rs1_q), 16'(mRs1));
    chk("rs2_q", 16'(rif.rs2_q), 16'(mRs2));
    chk("out_valid", 16'(rif.out_valid), 16'(mVld));
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mRegs[i] = 16'h0;
    mOp1 = 0; mOp2 = 0; mRs1 = 0; mRs2 = 0; mVld = 0;

    // 1. reset then read
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 3, 16'h5555, 1, 0, 0, 0, 0);  // write blocked by reset
    chk("rst_valid", 16'(rif.out_valid), 16'h0);
    step(0, 0, 0, 0, 1, 3, 5, 0, 0);
    chk("t1_op1", rif.op1_q, 16'h0);
    chk("t1_op2", rif.op2_q, 16'h0);
    chk("t1_valid", 16'(rif.out_valid), 16'h1);

    // 2. write with bypass, then plain read
    step(0, 1, 2, 16'hBEEF, 1, 2, 5, 0, 0);
    chk("t2_bypass", rif.op1_q, 16'hBEEF);
    step(0, 0, 0, 0, 1, 2, 5, 0, 0);
    chk("t2_read", rif.op1_q, 16'hBEEF);

    // 3. stall refresh
    step(0, 1, 4, 16'h0011, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 1, 1, 4, 0, 0);
    chk("t3_pre", rif.op2_q, 16'h0011);
    step(0, 1, 4, 16'h1234, 0, 7, 7, 1, 0);
    chk("t3_op2", rif.op2_q, 16'h1234);
    chk("t3_rs2", 16'(rif.rs2_q), 16'h4);
    chk("t3_valid", 16'(rif.out_valid), 16'h1);

    // 4. flush beats stall
    step(0, 0, 0, 0, 1, 2, 4, 1, 1);
    chk("t4_valid", 16'(rif.out_valid), 16'h0);
    chk("t4_op1", rif.op1_q, 16'h0);
    chk("t4_op2", rif.op2_q, 16'h0);

    // 5. write during flush
    step(0, 1, 6, 16'h00AA, 1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 6, 6, 0, 0);
    chk("t5_op1", rif.op1_q, 16'h00AA);
    chk("t5_op2", rif.op2_q, 16'h00AA);

    // 6. zero register
    step(0, 1, 0, 16'hFFFF, 1, 1, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 2, 0, 0);
    chk("t6_zero", rif.op1_q, ZERO ? 16'h0 : 16'hFFFF);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 63) == 0),
           1'($urandom), 3'($urandom), 16'($urandom), 1'($urandom),
           3'($urandom), 3'($urandom),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule
